// File: rtl/cache_pkg.sv
// Shared types and constants for the sample-cache write scheduler.
package cache_pkg;

   localparam int unsigned ADDR_W_DEF = 8;
   localparam int unsigned BANK_WORDS = 2 ** (ADDR_W_DEF - 1);
   localparam logic [3:0]  USB_STATE_DATA = 4'd6;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_REQ     = 2'd1,
      ST_FILL    = 2'd2,
      ST_HANDOFF = 2'd3
   } sched_state_e;

endpackage

// File: rtl/toggle_sync.sv
// Two-flop synchronizer for a toggle signal with a one-cycle edge pulse.
module toggle_sync (
   input  logic clk_i,
   input  logic rst_n,
   input  logic tgl_i,
   output logic pulse_c
);

   logic sync1_q;
   logic sync2_q;
   logic prev_q;

   always_ff @(posedge clk_i or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         prev_q  <= 1'b0;
      end else begin
         sync1_q <= tgl_i;
         sync2_q <= sync1_q;
         prev_q  <= sync2_q;
      end
   end

   assign pulse_c = sync2_q ^ prev_q;

endmodule

// File: rtl/cache_bank_sched.sv
// Ping-pong bank write scheduler: requests USB bursts into a free bank and
// hands each filled bank to the read clock domain via a toggle.
module cache_bank_sched
   import cache_pkg::*;
#(
   parameter int unsigned ADDR_W = ADDR_W_DEF
) (
   input  logic              wrclock,
   input  logic              rst_n,
   input  logic              usb_data_rdy,
   input  logic              usb_word_vld,
   input  logic              usb_rd_done,
   output logic              usb_rd_req,
   output logic [ADDR_W-1:0] wraddress,
   output logic              wren,
   output logic              bank_rdy_tgl,
   input  logic              bank_free_tgl,
   output logic [1:0]        bank_owned,
   output logic              overflow
);

   localparam int unsigned     CNT_W    = ADDR_W - 1;
   localparam logic [CNT_W-1:0] CNT_LAST = '1;

   sched_state_e     state_q;
   logic             wr_bank_q;
   logic             rd_bank_q;
   logic [CNT_W-1:0] word_cnt_q;
   logic             rd_req_q;
   logic             rdy_tgl_q;
   logic             ovf_q;
   logic [1:0]       owned_q;

   logic             free_c;
   logic             fill_c;
   logic             wr_c;
   logic             last_c;
   logic [1:0]       clr_c;
   logic [1:0]       set_c;

   toggle_sync u_free_sync (
      .clk_i   (wrclock),
      .rst_n   (rst_n),
      .tgl_i   (bank_free_tgl),
      .pulse_c (free_c)
   );

   // Ownership clear (oldest bank) is applied before the handoff set.
   always_comb begin
      fill_c = (state_q == ST_FILL);
      wr_c   = fill_c && usb_word_vld;
      last_c = wr_c && (word_cnt_q == CNT_LAST);
      clr_c  = free_c ? (2'b01 << rd_bank_q) : 2'b00;
      set_c  = last_c ? (2'b01 << wr_bank_q) : 2'b00;
   end

   always_ff @(posedge wrclock or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         wr_bank_q  <= 1'b0;
         rd_bank_q  <= 1'b0;
         word_cnt_q <= '0;
         rd_req_q   <= 1'b0;
         rdy_tgl_q  <= 1'b0;
         ovf_q      <= 1'b0;
         owned_q    <= 2'b00;
      end else begin
         rd_req_q <= 1'b0;
         owned_q  <= (owned_q & ~clr_c) | set_c;
         if (free_c) rd_bank_q <= ~rd_bank_q;
         if (usb_word_vld && !fill_c) ovf_q <= 1'b1;
         case (state_q)
            ST_IDLE: begin
               if (usb_data_rdy && !owned_q[wr_bank_q]) begin
                  state_q  <= ST_REQ;
                  rd_req_q <= 1'b1;
               end
            end
            ST_REQ: state_q <= ST_FILL;
            ST_FILL: begin
               // Last word wins over a coincident burst end.
               if (last_c) begin
                  state_q   <= ST_HANDOFF;
                  rdy_tgl_q <= ~rdy_tgl_q;
               end else begin
                  if (wr_c) word_cnt_q <= CNT_W'(word_cnt_q + 1'b1);
                  if (usb_rd_done) state_q <= ST_IDLE;
               end
            end
            ST_HANDOFF: begin
               wr_bank_q  <= ~wr_bank_q;
               word_cnt_q <= '0;
               state_q    <= ST_IDLE;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign usb_rd_req   = rd_req_q;
   assign bank_rdy_tgl = rdy_tgl_q;
   assign bank_owned   = owned_q;
   assign overflow     = ovf_q;
   assign wren         = wr_c;
   assign wraddress    = {wr_bank_q, word_cnt_q};

endmodule

// File: tb/tb_cache_bank_sched.sv
// Scoreboard bench for cache_bank_sched: expected write addresses are queued
// as words are driven and popped when the DUT asserts wren.
module tb_cache_bank_sched;
   import cache_pkg::*;

   localparam int unsigned AW = ADDR_W_DEF;

   logic          wrclock;
   logic          rst_n;
   logic          usb_data_rdy;
   logic          usb_word_vld;
   logic          usb_rd_done;
   logic          usb_rd_req;
   logic [AW-1:0] wraddress;
   logic          wren;
   logic          bank_rdy_tgl;
   logic          bank_free_tgl;
   logic [1:0]    bank_owned;
   logic          overflow;

   int            checks  = 0;
   int            errors  = 0;
   int            req_cnt = 0;
   int            m_bank;
   int            m_cnt;
   logic [AW-1:0] exp_q[$];
   logic [AW-1:0] exp_a;

   cache_bank_sched #(.ADDR_W(AW)) dut (
      .wrclock       (wrclock),
      .rst_n         (rst_n),
      .usb_data_rdy  (usb_data_rdy),
      .usb_word_vld  (usb_word_vld),
      .usb_rd_done   (usb_rd_done),
      .usb_rd_req    (usb_rd_req),
      .wraddress     (wraddress),
      .wren          (wren),
      .bank_rdy_tgl  (bank_rdy_tgl),
      .bank_free_tgl (bank_free_tgl),
      .bank_owned    (bank_owned),
      .overflow      (overflow)
   );

   initial wrclock = 1'b0;
   always #5 wrclock = ~wrclock;

   // Write-port monitor, sampled mid-cycle.
   always @(negedge wrclock) begin
      if (rst_n) begin
         if (usb_rd_req) req_cnt++;
         if (wren) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL wr_unexpected: wren=1 wraddress=%0d, required no write", wraddress);
            end else begin
               exp_a = exp_q.pop_front();
               if (wraddress !== exp_a) begin
                  errors++;
                  $display("FAIL wraddress: got %0d, required %0d", wraddress, exp_a);
               end
            end
         end
      end
   end

   task automatic tick();
      @(posedge wrclock);
      #1;
   endtask

   task automatic apply_reset();
      rst_n         = 1'b0;
      usb_data_rdy  = 1'b0;
      usb_word_vld  = 1'b0;
      usb_rd_done   = 1'b0;
      bank_free_tgl = 1'b0;
      m_bank        = 0;
      m_cnt         = 0;
      exp_q.delete();
      repeat (2) @(posedge wrclock);
      #1;
      rst_n   = 1'b1;
      req_cnt = 0;
   endtask

   // Wait (bounded) for the burst request, then step into the fill state.
   task automatic start_burst();
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 100 && !seen; i++) begin
         tick();
         if (usb_rd_req === 1'b1) seen = 1'b1;
      end
      checks++;
      if (!seen) begin
         errors++;
         $display("FAIL rd_req_timeout: usb_rd_req=%b after 100 cycles, required 1", usb_rd_req);
      end
      usb_data_rdy = 1'b0;
      tick();
   endtask

   task automatic drive_words(input int n, input bit done, input int free_at);
      for (int i = 0; i < n; i++) begin
         usb_word_vld = 1'b1;
         usb_rd_done  = done && (i == n - 1);
         exp_q.push_back(AW'(m_bank * int'(BANK_WORDS) + m_cnt));
         m_cnt++;
         if (m_cnt == int'(BANK_WORDS)) begin
            m_cnt  = 0;
            m_bank = m_bank ^ 1;
         end
         if (i == free_at) bank_free_tgl = ~bank_free_tgl;
         if (free_at >= 0 && i == n - 1) begin
            checks++;
            if (bank_owned !== 2'b01) begin
               errors++;
               $display("FAIL owned_pre_handoff: got %b, required 01", bank_owned);
            end
         end
         tick();
      end
      usb_word_vld = 1'b0;
      usb_rd_done  = 1'b0;
   endtask

   task automatic check_drained(input string tag);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL %s_drained: %0d writes missing, required 0", tag, exp_q.size());
      end
   endtask

   task automatic test_reset();
      apply_reset();
      checks += 6;
      if (usb_rd_req !== 1'b0)      begin errors++; $display("FAIL rst_rd_req: got %b, required 0", usb_rd_req); end
      if (wren !== 1'b0)            begin errors++; $display("FAIL rst_wren: got %b, required 0", wren); end
      if (wraddress !== '0)         begin errors++; $display("FAIL rst_wraddress: got %0d, required 0", wraddress); end
      if (bank_rdy_tgl !== 1'b0)    begin errors++; $display("FAIL rst_rdy_tgl: got %b, required 0", bank_rdy_tgl); end
      if (bank_owned !== 2'b00)     begin errors++; $display("FAIL rst_owned: got %b, required 00", bank_owned); end
      if (overflow !== 1'b0)        begin errors++; $display("FAIL rst_overflow: got %b, required 0", overflow); end
   endtask

   task automatic test_full_burst();
      apply_reset();
      usb_data_rdy = 1'b1;
      start_burst();
      drive_words(int'(BANK_WORDS), 1'b0, -1);
      checks += 4;
      if (bank_rdy_tgl !== 1'b1) begin errors++; $display("FAIL full_rdy_tgl: got %b, required 1", bank_rdy_tgl); end
      if (bank_owned !== 2'b01)  begin errors++; $display("FAIL full_owned: got %b, required 01", bank_owned); end
      if (req_cnt != 1)          begin errors++; $display("FAIL full_req_cnt: got %0d, required 1", req_cnt); end
      if (overflow !== 1'b0)     begin errors++; $display("FAIL full_overflow: got %b, required 0", overflow); end
      check_drained("full");
   endtask

   task automatic test_both_owned();
      apply_reset();
      for (int b = 0; b < 2; b++) begin
         usb_data_rdy = 1'b1;
         start_burst();
         drive_words(int'(BANK_WORDS), 1'b0, -1);
      end
      usb_data_rdy = 1'b1;
      repeat (20) tick();
      checks += 2;
      if (bank_owned !== 2'b11) begin errors++; $display("FAIL both_owned: got %b, required 11", bank_owned); end
      if (req_cnt != 2)         begin errors++; $display("FAIL both_no_req: got %0d requests, required 2", req_cnt); end
      bank_free_tgl = ~bank_free_tgl;
      repeat (2) tick();
      checks++;
      if (bank_owned !== 2'b11) begin errors++; $display("FAIL free_early: got %b, required 11", bank_owned); end
      tick();
      checks++;
      if (bank_owned !== 2'b10) begin errors++; $display("FAIL free_3cyc: got %b, required 10", bank_owned); end
      start_burst();
      checks++;
      if (req_cnt != 3) begin errors++; $display("FAIL free_req_cnt: got %0d, required 3", req_cnt); end
      drive_words(int'(BANK_WORDS), 1'b0, -1);
      checks++;
      if (bank_owned !== 2'b11) begin errors++; $display("FAIL refill_owned: got %b, required 11", bank_owned); end
      check_drained("both");
   endtask

   task automatic test_short_bursts();
      apply_reset();
      usb_data_rdy = 1'b1;
      start_burst();
      drive_words(50, 1'b1, -1);
      repeat (3) tick();
      checks += 2;
      if (bank_owned !== 2'b00)  begin errors++; $display("FAIL short_owned: got %b, required 00", bank_owned); end
      if (bank_rdy_tgl !== 1'b0) begin errors++; $display("FAIL short_rdy_tgl: got %b, required 0", bank_rdy_tgl); end
      usb_data_rdy = 1'b1;
      start_burst();
      drive_words(78, 1'b0, -1);
      checks += 4;
      if (bank_rdy_tgl !== 1'b1) begin errors++; $display("FAIL short2_rdy_tgl: got %b, required 1", bank_rdy_tgl); end
      if (bank_owned !== 2'b01)  begin errors++; $display("FAIL short2_owned: got %b, required 01", bank_owned); end
      if (overflow !== 1'b0)     begin errors++; $display("FAIL short2_overflow: got %b, required 0", overflow); end
      if (req_cnt != 2)          begin errors++; $display("FAIL short2_req_cnt: got %0d, required 2", req_cnt); end
      check_drained("short");
   endtask

   task automatic test_overflow();
      apply_reset();
      usb_word_vld = 1'b1;
      #1;
      checks++;
      if (wren !== 1'b0) begin errors++; $display("FAIL ovf_wren: got %b, required 0", wren); end
      tick();
      usb_word_vld = 1'b0;
      checks++;
      if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_set: got %b, required 1", overflow); end
      repeat (10) tick();
      checks++;
      if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b, required 1", overflow); end
      apply_reset();
      checks++;
      if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_reset: got %b, required 0", overflow); end
   endtask

   task automatic test_simul_free_handoff();
      apply_reset();
      usb_data_rdy = 1'b1;
      start_burst();
      drive_words(int'(BANK_WORDS), 1'b0, -1);
      usb_data_rdy = 1'b1;
      start_burst();
      drive_words(int'(BANK_WORDS), 1'b0, int'(BANK_WORDS) - 3);
      checks += 2;
      if (bank_owned !== 2'b10)  begin errors++; $display("FAIL simul_owned: got %b, required 10", bank_owned); end
      if (bank_rdy_tgl !== 1'b0) begin errors++; $display("FAIL simul_rdy_tgl: got %b, required 0", bank_rdy_tgl); end
      check_drained("simul");
   endtask

   task automatic test_reset_midfill();
      apply_reset();
      usb_data_rdy = 1'b1;
      start_burst();
      drive_words(int'(BANK_WORDS), 1'b0, -1);
      usb_data_rdy = 1'b1;
      start_burst();
      drive_words(60, 1'b0, -1);
      usb_word_vld = 1'b1;
      rst_n        = 1'b0;
      #1;
      checks += 6;
      if (wren !== 1'b0)         begin errors++; $display("FAIL mid_wren: got %b, required 0", wren); end
      if (wraddress !== '0)      begin errors++; $display("FAIL mid_wraddress: got %0d, required 0", wraddress); end
      if (usb_rd_req !== 1'b0)   begin errors++; $display("FAIL mid_rd_req: got %b, required 0", usb_rd_req); end
      if (bank_rdy_tgl !== 1'b0) begin errors++; $display("FAIL mid_rdy_tgl: got %b, required 0", bank_rdy_tgl); end
      if (bank_owned !== 2'b00)  begin errors++; $display("FAIL mid_owned: got %b, required 00", bank_owned); end
      if (overflow !== 1'b0)     begin errors++; $display("FAIL mid_overflow: got %b, required 0", overflow); end
      usb_word_vld = 1'b0;
      check_drained("mid_pre");
      apply_reset();
      usb_data_rdy = 1'b1;
      start_burst();
      drive_words(int'(BANK_WORDS), 1'b0, -1);
      checks += 2;
      if (bank_rdy_tgl !== 1'b1) begin errors++; $display("FAIL mid_refill_tgl: got %b, required 1", bank_rdy_tgl); end
      if (bank_owned !== 2'b01)  begin errors++; $display("FAIL mid_refill_owned: got %b, required 01", bank_owned); end
      check_drained("mid");
   endtask

   initial begin
      rst_n         = 1'b0;
      usb_data_rdy  = 1'b0;
      usb_word_vld  = 1'b0;
      usb_rd_done   = 1'b0;
      bank_free_tgl = 1'b0;
      test_reset();
      test_full_burst();
      test_both_owned();
      test_short_bursts();
      test_overflow();
      test_simul_free_handoff();
      test_reset_midfill();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/cache_bank_sched.md
# cache_bank_sched

Write-side scheduler for the 256-word dual-clock sample cache between the USB3 slave-FIFO reader and the DA playback path. It splits the cache into two ping-pong banks and requests USB bursts only when a bank is free. It drives the cache write port and hands each filled bank to the rdclock domain through a toggle handshake. This replaces free-running write addressing, so the DA side never reads a bank that is still being written.

## Interface
- ADDR_W, 8, cache address width; each bank holds BANK_WORDS = 2^(ADDR_W-1) words (128 at default).
- wrclock  in  1  write/USB clock; every register in this block is on it.
- rst_n  in  1  reset, asynchronous, active-low.
- usb_data_rdy  in  1  USB FIFO holds at least one bank of data; already synchronous to wrclock.
- usb_word_vld  in  1  USB reader presents a valid 32-bit word this cycle; the data bus goes straight to the cache.
- usb_rd_done  in  1  one-cycle pulse marking the end of the current USB burst.
- usb_rd_req  out  1  one-cycle pulse that starts a USB burst.
- wraddress  out  ADDR_W  cache write address; MSB is the bank index.
- wren  out  1  cache write enable.
- bank_rdy_tgl  out  1  toggles once per bank handed to the read side.
- bank_free_tgl  in  1  from the rdclock domain; toggles once per bank fully drained.
- bank_owned  out  2  bit b is high while the read side owns bank b.
- overflow  out  1  sticky; a word arrived that could not be written.

## Operation
- FSM states: IDLE, REQ, FILL, HANDOFF.
- IDLE:
  - go to REQ when usb_data_rdy=1 and bank_owned[wr_bank]=0.
  - Otherwise stay in IDLE.
- REQ: assert usb_rd_req for exactly one cycle, then go to FILL.
- FILL:
  - wren = usb_word_vld; wraddress = {wr_bank, word_cnt}.
  - Each valid word increments word_cnt.
  - A valid word at word_cnt = BANK_WORDS-1 goes to HANDOFF.
  - usb_rd_done before that point is a short burst: go back to IDLE and keep word_cnt, so the bank is completed by later bursts.
  - If usb_rd_done coincides with the last word, HANDOFF takes priority.
- HANDOFF (one cycle):
  - toggle bank_rdy_tgl and set bank_owned[wr_bank].
  - flip wr_bank, clear word_cnt, go to IDLE.
- Free path:
  - bank_free_tgl passes through a 2-flop synchronizer and edge detector.
  - Each detected edge clears bank_owned[rd_bank], then flips rd_bank. Banks are always drained in handoff order.
  - A set in HANDOFF and a clear from a free edge in the same cycle both take effect, including on the same bit (clear of the old ownership first, then set).
- overflow sets on usb_word_vld=1 in any state other than FILL. The word is dropped (wren=0).
- overflow clears only on reset.
- word_cnt arithmetic is ADDR_W-1 bits and wraps only through HANDOFF; it never wraps silently.

## Timing
- Reset values:
  - outputs: usb_rd_req=0, wren=0, wraddress=0, bank_rdy_tgl=0, bank_owned=00, overflow=0.
  - internal: wr_bank=0, rd_bank=0, word_cnt=0, synchronizer flops 0, state IDLE.
- wren and wraddress are combinational from the registered state and counter, so wren is aligned with usb_word_vld with zero latency.
- usb_rd_req is registered. It rises 1 cycle after IDLE sees both usb_data_rdy=1 and a free bank.
- bank_rdy_tgl changes 1 cycle after the last word's write cycle.
- A bank_free_tgl edge clears bank_owned 3 wrclock cycles later. The read side must not toggle faster than once per 3 wrclock cycles, which is guaranteed by BANK_WORDS reads per toggle.
- Reset mid-fill discards the partial bank. rdclock logic shares rst_n.

## Structure
- Package cache_pkg holds: the FSM state enum, the ADDR_W default, the BANK_WORDS localparam, and USB_STATE_DATA=4'd6 used by the reader to form usb_word_vld.
- Sub-module toggle_sync: 2-flop synchronizer plus edge-detect pulse. Instantiated once here and reused on the rdclock side for bank_rdy_tgl.

## Test plan
- Reset, then usb_data_rdy=1 with 128 continuous valid words:
  - usb_rd_req pulses once.
  - wraddress runs 0..127 with wren=1.
  - bank_rdy_tgl goes 0→1 and bank_owned goes 00→01.
- Two full bursts with no free toggle, then a third usb_data_rdy:
  - bank_owned=11, no third usb_rd_req.
  - After one bank_free_tgl edge, bank_owned=10 three cycles later, and usb_rd_req fires toward bank 0.
- Bursts of 50 + 78 words with usb_rd_done between them:
  - addresses 0..49 then 50..127, one handoff after word 127.
  - no overflow.
- usb_word_vld asserted in IDLE: wren stays 0 and overflow=1 until reset.
- A free edge synchronized in the same cycle as HANDOFF: both the clear and the set on bank_owned take effect.
- rst_n low at word 60: all outputs go to reset values asynchronously, and the next burst writes from address 0.
